line_rasterizer: RTL and testbench
==================================

// Module: line_rasterizer
// PURPOSE
//  Hardware Bresenham line drawer feeding the back buffer's write port (din/waddr/we), replacing
//  per-pixel NIOS stores for wireframe edges. The processor latches two endpoints plus a colour id
//  and pulses start. The block emits one pixel write per cycle in column-major address form.
//  Pixel address is waddr = y + 240*x, matching the buffer layout.
// PARAMETERS
//  NUMBER_COLORS  9    palette size; colour width CW = $clog2(NUMBER_COLORS)+1 (=5 at default)
//  H_RES          320  horizontal pixels (x range 0..H_RES-1)
//  V_RES          240  vertical pixels (y range 0..V_RES-1); also the address column stride
// PORTS
//  clk      in   1    system clock (CLOCK_50 domain)
//  reset    in   1    synchronous, active-high reset
//  start    in   1    1-cycle request; sampled only in IDLE
//  x0,x1    in   9    endpoint x coordinates, unsigned
//  y0,y1    in   8    endpoint y coordinates, unsigned
//  color    in   CW   colour id written to every pixel of the line
//  stall    in   1    back-buffer port busy; freezes stepping, forces we=0
//  busy     out  1    high from the cycle after start acceptance until done clears
//  done     out  1    1-cycle pulse after the last pixel write
//  waddr    out  17   back-buffer address, $clog2(320*240) bits
//  din      out  CW   back-buffer write data
//  we       out  1    back-buffer write enable
// BEHAVIOUR
//  - Reset: state=IDLE, busy=0, done=0, we=0, waddr=0, din=0. Reset overrides start and stall.
//    Reset mid-line aborts with no further writes and no done pulse.
//  - All outputs are registered. FSM states: IDLE -> SETUP -> DRAW -> FIN -> IDLE.
//  - IDLE: if start=1 at edge N, latch x0,y0,x1,y1,color into registers and go to SETUP; busy=1 from N.
//  - SETUP (1 cycle):
//    - dx = |x1-x0| (10b); dy = -|y1-y0| (10b signed)
//    - sx = (x0<x1) ? +1 : -1; sy = (y0<y1) ? +1 : -1
//    - err = dx+dy (11b signed); cur = (x0,y0)
//  - DRAW, stall=0: register waddr = cur_y + 240*cur_x, din = color, we = 1.
//    - If cur == (x1,y1), go to FIN.
//    - Otherwise step with e2 = 2*err (12b signed):
//      - if e2 >= dy: err += dy, cur_x += sx
//      - if e2 <= dx: err += dx, cur_y += sy
//      - if both conditions hold, apply both updates in the same cycle (err gets dx+dy).
//  - DRAW, stall=1: we=0; cur, err and state are held; resume exactly where stepping stopped.
//  - FIN: we=0, done=1 for 1 cycle, busy=0 from the next cycle; return to IDLE.
//  - Latency: start at edge N -> first we=1 after edge N+2.
//    N_pix = max(|dx|,|dy|)+1 write cycles, not counting stall cycles.
//  - Degenerate line (x0==x1 and y0==y1): exactly 1 write, then done.
//  - start while busy: ignored; latched operands do not change.
//  - Address multiply uses the constant 240 (shift-add permitted) and is truncated to 17 bits.
// CONFIGURATION
//  LINE_RASTER_CLIP_EN
//   - defined: a pixel with cur_x >= H_RES or cur_y >= V_RES is stepped normally but gets we=0.
//     Clipped pixels still count toward N_pix, so done timing is unchanged.
//   - undefined: every pixel is written. Out-of-range pixels produce the truncated address;
//     the caller must supply in-range endpoints.
// TESTING
//  - Horizontal (0,0)->(3,0), colour 5: we high 4 cycles starting edge N+2; waddr 0,240,480,720;
//    din=5; done 1 cycle later.
//  - Steep (10,10)->(12,15): 6 writes at y=10..15, x sequence 10,10,11,11,12,12 (Bresenham);
//    busy drops after done.
//  - Point (7,7)->(7,7): single write waddr=1687, then done.
//  - stall=1 for 3 cycles mid-line (319,0)->(0,239): we=0 while stalled, no pixel skipped or
//    duplicated; total 320 writes.
//  - reset asserted during DRAW: next cycle we=0, busy=0; done never pulses; new start then works.
//  - CLIP_EN: (300,230)->(330,250) -> writes only where x<320 and y<240, done timing equals the
//    unclipped run; without CLIP_EN, all 31 pixels are written.

Source files
------------

// File: rtl/line_rasterizer.sv
// line_rasterizer: Bresenham line drawer writing column-major pixels (y + V_RES*x) to the back buffer; define LINE_RASTER_CLIP_EN to suppress off-screen writes
module line_rasterizer #(
  parameter int NUMBER_COLORS = 9,
  parameter int H_RES = 320,
  parameter int V_RES = 240,
  localparam int CW = $clog2(NUMBER_COLORS) + 1,
  localparam int AW = $clog2(H_RES * V_RES)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [8:0]    x0,
  input  logic [8:0]    x1,
  input  logic [7:0]    y0,
  input  logic [7:0]    y1,
  input  logic [CW-1:0] color,
  input  logic          stall,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] waddr,
  output logic [CW-1:0] din,
  output logic          we
);
  typedef enum logic [1:0] {IDLE, SETUP, DRAW, FIN} state_t;
  state_t             r_state;
  logic [8:0]         r_x0, r_x1, r_cx;
  logic [7:0]         r_y0, r_y1, r_cy;
  logic [CW-1:0]      r_col;
  logic [9:0]         r_dx;
  logic signed [9:0]  r_dy;
  logic signed [10:0] r_err;
  logic               r_sx, r_sy;
  logic [8:0]         w_adx;
  logic [7:0]         w_ady;
  logic signed [11:0] w_e2, w_dx12, w_dy12;
  logic signed [10:0] w_err_nx;
  logic               w_step_x, w_step_y, w_at_end, w_vis;
  logic [AW-1:0]      w_addr;
  // Step decision, next error term, pixel address and on-screen test for the current point
  always_comb begin
    w_adx    = (r_x1 >= r_x0) ? r_x1 - r_x0 : r_x0 - r_x1;
    w_ady    = (r_y1 >= r_y0) ? r_y1 - r_y0 : r_y0 - r_y1;
    w_e2     = {r_err, 1'b0};
    w_dx12   = {2'b0, r_dx};
    w_dy12   = {{2{r_dy[9]}}, r_dy};
    w_step_x = w_e2 >= w_dy12;
    w_step_y = w_e2 <= w_dx12;
    w_err_nx = r_err + (w_step_x ? {r_dy[9], r_dy} : 11'sd0) + (w_step_y ? {1'b0, r_dx} : 11'sd0);
    w_at_end = (r_cx == r_x1) && (r_cy == r_y1);
    w_addr   = AW'(r_cy) + AW'(r_cx) * AW'(V_RES);
`ifdef LINE_RASTER_CLIP_EN
    w_vis    = (32'(r_cx) < H_RES) && (32'(r_cy) < V_RES);
`else
    w_vis    = 1'b1;
`endif
  end
  // Control FSM: latch operands, set up Bresenham terms, emit one pixel per unstalled cycle, pulse done
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      we      <= 1'b0;
      waddr   <= '0;
      din     <= '0;
    end else begin
      we   <= 1'b0;
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          busy <= start;
          if (start) begin
            r_x0    <= x0;
            r_y0    <= y0;
            r_x1    <= x1;
            r_y1    <= y1;
            r_col   <= color;
            r_state <= SETUP;
          end
        end
        SETUP: begin
          r_dx    <= {1'b0, w_adx};
          r_dy    <= -{2'b0, w_ady};
          r_err   <= {2'b0, w_adx} - {3'b0, w_ady};
          r_sx    <= r_x0 < r_x1;
          r_sy    <= r_y0 < r_y1;
          r_cx    <= r_x0;
          r_cy    <= r_y0;
          r_state <= DRAW;
        end
        DRAW: begin
          if (!stall) begin
            waddr <= w_addr;
            din   <= r_col;
            we    <= w_vis;
            if (w_at_end) r_state <= FIN;
            else begin
              r_err <= w_err_nx;
              if (w_step_x) r_cx <= r_sx ? r_cx + 9'd1 : r_cx - 9'd1;
              if (w_step_y) r_cy <= r_sy ? r_cy + 8'd1 : r_cy - 8'd1;
            end
          end
        end
        FIN: begin
          done    <= 1'b1;
          r_state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_line_rasterizer.sv
// tb_line_rasterizer: randomized scoreboard bench for line_rasterizer against a plain Bresenham reference
module tb_line_rasterizer;
  logic        clk = 1'b0, reset = 1'b1, start = 1'b0, stall = 1'b0;
  logic [8:0]  x0 = '0, x1 = '0;
  logic [7:0]  y0 = '0, y1 = '0;
  logic [4:0]  color = '0;
  logic        busy, done, we;
  logic [16:0] waddr;
  logic [4:0]  din;
  int n_chk = 0, n_fail = 0;
  int q_addr[$], q_col[$];
  int px[$], py[$];
  bit pv[$];

  line_rasterizer dut (
    .clk(clk), .reset(reset), .start(start), .x0(x0), .x1(x1), .y0(y0), .y1(y1),
    .color(color), .stall(stall), .busy(busy), .done(done), .waddr(waddr), .din(din), .we(we)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic bit vis(input int x, input int y);
`ifdef LINE_RASTER_CLIP_EN
    return (x < 320) && (y < 240);
`else
    return 1'b1;
`endif
  endfunction

  // Reference: the textbook integer Bresenham walk, producing the ordered pixel list
  function automatic void model(input int ax0, ay0, ax1, ay1);
    int dx, dy, sx, sy, err, e2, x, y;
    dx = (ax1 >= ax0) ? ax1 - ax0 : ax0 - ax1;
    dy = -((ay1 >= ay0) ? ay1 - ay0 : ay0 - ay1);
    sx = (ax0 < ax1) ? 1 : -1;
    sy = (ay0 < ay1) ? 1 : -1;
    err = dx + dy;
    x = ax0;
    y = ay0;
    px.delete(); py.delete(); pv.delete();
    while (1) begin
      px.push_back(x); py.push_back(y); pv.push_back(vis(x, y));
      if (x == ax1 && y == ay1) break;
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; x += sx; end
      if (e2 <= dx) begin err += dx; y += sy; end
    end
  endfunction

  task automatic push_expected(input int acol);
    foreach (px[i]) if (pv[i]) begin
      q_addr.push_back(py[i] + 240 * px[i]);
      q_col.push_back(acol);
    end
  endtask

  // Monitor: every observed write must match the oldest expected pixel
  always @(negedge clk) if (we) begin
    if (q_addr.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL unexpected_write: we=1 addr %0d din %0d with no pixel pending", waddr, din);
    end else begin
      chk("waddr", int'(waddr), q_addr.pop_front());
      chk("din", int'(din), q_col.pop_front());
    end
  end

  // smode: 0 no stall, 1 random stall, 2 three-cycle stall burst mid-line
  task automatic run_line(input int ax0, ay0, ax1, ay1, acol, smode);
    int n, idx, done_k, ew;
    bit s;
    model(ax0, ay0, ax1, ay1);
    push_expected(acol);
    n = px.size();
    @(negedge clk);
    x0 = 9'(ax0); y0 = 8'(ay0); x1 = 9'(ax1); y1 = 8'(ay1); color = 5'(acol);
    start = 1'b1; stall = 1'b0;
    @(posedge clk); #1;
    chk("busy_accept", int'(busy), 1);
    chk("we_accept", int'(we), 0);
    idx = 0;
    done_k = -1;
    for (int k = 1; k < 6000; k++) begin
      @(negedge clk);
      start = (k <= 2);
      x0 = 9'($urandom); y0 = 8'($urandom); x1 = 9'($urandom); y1 = 8'($urandom); color = 5'($urandom);
      s = (smode == 1) ? ($urandom_range(3) == 0) : (smode == 2) ? (k >= 40 && k <= 42) : 1'b0;
      stall = s;
      @(posedge clk);
      ew = 0;
      if (k >= 2 && idx < n && !s) begin
        ew = int'(pv[idx]);
        idx++;
        if (idx == n) done_k = k + 1;
      end
      #1;
      chk("we_timing", int'(we), ew);
      chk("done_timing", int'(done), int'(k == done_k));
      chk("busy", int'(busy), int'(done_k < 0 || k <= done_k));
      if (done_k > 0 && k == done_k + 1) break;
    end
    start = 1'b0;
    stall = 1'b0;
    chk("line_drained", q_addr.size(), 0);
  endtask

  task automatic run_abort();
    model(0, 0, 300, 100);
    push_expected(7);
    @(negedge clk);
    x0 = 9'd0; y0 = 8'd0; x1 = 9'd300; y1 = 8'd100; color = 5'd7; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    q_addr.delete();
    q_col.delete();
    #1;
    chk("abort_we", int'(we), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      chk("abort_no_done", int'(done), 0);
      chk("abort_idle", int'(busy), 0);
    end
  endtask

  initial begin
    int ax0, ay0, ax1, ay1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_we", int'(we), 0);
    chk("rst_waddr", int'(waddr), 0);
    chk("rst_din", int'(din), 0);
    @(negedge clk);
    reset = 1'b0;
    run_line(0, 0, 3, 0, 5, 0);
    run_line(10, 10, 12, 15, 9, 1);
    run_line(7, 7, 7, 7, 3, 0);
    run_line(319, 0, 0, 239, 6, 2);
    run_line(300, 230, 330, 250, 12, 0);
    run_abort();
    run_line(5, 200, 60, 180, 1, 1);
    for (int i = 0; i < 25; i++) begin
      ax0 = $urandom_range(319);
      ay0 = $urandom_range(239);
      ax1 = (i % 4 == 0) ? ax0 : $urandom_range(319);
      ay1 = (i % 4 == 0) ? ay0 : $urandom_range(239);
      run_line(ax0, ay0, ax1, ay1, $urandom_range(31), $urandom_range(2));
    end
    chk("sb_empty", q_addr.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
